csr_addr_fifo: RTL and testbench
================================

// Module: csr_addr_fifo
// PURPOSE
//  Multi-entry, in-order buffer of pending CSR operations. It is the generalised successor of the
//  single-entry CSR address buffer and acts as a functional unit to the scoreboard.
//  Issue pushes CSR address, PC and transaction ID. Commit pops the oldest entry and presents it
//  to the CSR file. More than one CSR op can therefore be in flight between issue and commit.
// PARAMETERS
//  DEPTH       2           number of entries, >=1, need not be a power of two
//  VLEN        riscv::VLEN PC width (for FVT tracking)
//  XLEN        riscv::XLEN operand/result width
//  TRANS_ID_W  3           scoreboard transaction ID width
//  CNT_W       $clog2(DEPTH+1)  occupancy counter width (derived, not overridable)
// PORTS
//  clk_i         in   1           clock, rising edge
//  rst_ni        in   1           asynchronous reset, active-low
//  flush_i       in   1           discard all uncommitted entries
//  valid_i       in   1           issue: CSR op valid
//  addr_i        in   12          issue: CSR address (operand_b[11:0])
//  pc_i          in   VLEN        issue: PC of the CSR instruction
//  trans_id_i    in   TRANS_ID_W  issue: scoreboard ID
//  operand_i     in   XLEN        issue: operand_a
//  ready_o       out  1           buffer can accept an op this cycle
//  result_o      out  XLEN        writeback value, equal to operand_i (combinational)
//  commit_i      in   1           commit stage retires the oldest pending op
//  addr_o        out  12          head entry CSR address
//  pc_o          out  VLEN        head entry PC
//  trans_id_o    out  TRANS_ID_W  head entry trans ID
//  head_valid_o  out  1           head entry holds a pending op
//  count_o       out  CNT_W       number of pending entries
//  commit_err_o  out  1           one-cycle pulse: commit_i seen while empty
// BEHAVIOUR
//  - Storage: DEPTH x {addr, pc, trans_id}, circular, with read pointer rptr, write pointer wptr
//    and counter cnt. Pointers wrap from DEPTH-1 to 0 explicitly (no power-of-two masking).
//  - Reset: rptr = wptr = cnt = 0; storage cleared to 0.
//    Resulting outputs: ready_o = 1, head_valid_o = 0, addr_o / pc_o / trans_id_o = 0,
//    count_o = 0, commit_err_o = 0.
//  - ready_o = (cnt < DEPTH) || (commit_i && cnt != 0).
//    Combinational; it does not depend on valid_i. A full buffer accepts a new op in the same
//    cycle that it retires one.
//  - push = valid_i && ready_o && !flush_i. The entry is written at wptr, then wptr advances.
//  - pop = commit_i && cnt != 0. rptr advances.
//  - Counter update:
//    - push only: cnt += 1
//    - pop only: cnt -= 1
//    - push and pop together: cnt unchanged. Both pointers advance, so the new entry becomes
//      visible at the head one cycle later when cnt was 1.
//  - Head outputs are registered state. When cnt == 0, addr_o, pc_o and trans_id_o are driven
//    to 0 and head_valid_o = 0. An entry pushed in cycle N is visible at the head in cycle N+1
//    at the earliest (latency 1).
//  - commit_i with cnt == 0: no state change, and commit_err_o pulses high for 1 cycle in the
//    next cycle (registered). commit_err_o is a verification aid only.
//  - flush_i has priority over everything:
//    - next rptr = wptr = cnt = 0
//    - a push in the same cycle is dropped
//    - a commit in the same cycle is still treated as a retire; the commit stage has already
//      used addr_o. The flush result is empty regardless.
//    - Storage contents are don't-care after flush.
//  - valid_i while ready_o = 0: ignored, no state change. The scoreboard must hold the op.
//  - Overflow and underflow are impossible by construction. SVA required:
//    - cnt <= DEPTH
//    - (cnt == 0) -> !pop
//    - push -> cnt_q < DEPTH || pop
//  - Reset asserted mid-operation: all state is cleared asynchronously. Outputs return to
//    reset values in the same cycle.
// TESTING
//  1. DEPTH=2, reset then push addr 0x300 and 0x341 in consecutive cycles, no commit:
//     -> ready_o = 0 after the 2nd push, count_o = 2, addr_o = 0x300.
//  2. Full buffer with commit_i = 1 and valid_i = 1 (addr 0x305) in the same cycle:
//     -> count_o stays 2, addr_o = 0x341 the next cycle, then 0x305 after a further commit.
//  3. cnt = 1 with flush_i = 1, valid_i = 1, commit_i = 0:
//     -> next cycle count_o = 0, head_valid_o = 0, addr_o = 0. The pushed op is not stored.
//  4. Empty buffer, commit_i = 1 -> commit_err_o = 1 for exactly 1 cycle, count_o stays 0.
//  5. DEPTH=3, push/pop 10 ops with addresses 0x100..0x109 in random interleaving:
//     -> pops return 0x100..0x109 in order, and pc/trans_id stay matched across pointer wrap.
//  6. DEPTH=1: push 0x300, then rst_ni low mid-stream -> all outputs at reset values
//     immediately. After release, a push of 0x301 appears at the head 1 cycle later.

Source files
------------

// File: rtl/csr_addr_fifo.sv
// In-order buffer of pending CSR operations between issue and commit.
// Issue pushes {addr, pc, trans_id}. Commit retires the oldest entry, which is presented at the head.
module csr_addr_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned VLEN       = 64,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned TRANS_ID_W = 3,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [11:0]           addr_i,
  input  logic [VLEN-1:0]       pc_i,
  input  logic [TRANS_ID_W-1:0] trans_id_i,
  input  logic [XLEN-1:0]       operand_i,
  output logic                  ready_o,
  output logic [XLEN-1:0]       result_o,
  input  logic                  commit_i,
  output logic [11:0]           addr_o,
  output logic [VLEN-1:0]       pc_o,
  output logic [TRANS_ID_W-1:0] trans_id_o,
  output logic                  head_valid_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  commit_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [11:0]           addr;
    logic [VLEN-1:0]       pc;
    logic [TRANS_ID_W-1:0] trans_id;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_err_q, commit_err_d;
  logic             empty, push, pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign ready_o  = (cnt_q < FULL_CNT) || (commit_i && !empty);
  assign push     = valid_i && ready_o && !flush_i;
  assign pop      = commit_i && !empty;
  assign result_o = operand_i;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
    mem_d        = mem_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    commit_err_d = commit_i && empty;

    if (flush_i) begin
      // A same-cycle commit has already consumed the head; the result is empty either way.
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{addr: addr_i, pc: pc_i, trans_id: trans_id_i};
        wptr_d        = ptr_incr(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_incr(rptr_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      commit_err_q <= 1'b0;
      // NOTE: storage is reset too, so head outputs are defined from the first cycle.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      commit_err_q <= commit_err_d;
      mem_q        <= mem_d;
    end
  end

  // Head is masked to zero when nothing is pending (stale data may remain after a flush).
  assign head         = mem_q[rptr_q];
  assign addr_o       = empty ? '0 : head.addr;
  assign pc_o         = empty ? '0 : head.pc;
  assign trans_id_o   = empty ? '0 : head.trans_id;
  assign head_valid_o = !empty;
  assign count_o      = cnt_q;
  assign commit_err_o = commit_err_q;

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= FULL_CNT);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) empty |-> !pop);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  push |-> (cnt_q < FULL_CNT) || pop);

endmodule

// File: tb/tb_csr_addr_fifo.sv
// Directed bench for csr_addr_fifo at DEPTH 2, 3 and 1 against a queue-based scoreboard.
module tb_csr_addr_fifo;

  localparam int VLEN = 64;
  localparam int XLEN = 64;
  localparam int TW   = 3;
  localparam int NI   = 3;

  typedef struct packed {
    logic [11:0]     addr;
    logic [VLEN-1:0] pc;
    logic [TW-1:0]   tid;
  } entry_t;

  logic            clk_i;
  logic            rst_n    [NI];
  logic            flush    [NI];
  logic            valid    [NI];
  logic            commit   [NI];
  logic [11:0]     addr_in  [NI];
  logic [VLEN-1:0] pc_in    [NI];
  logic [TW-1:0]   tid_in   [NI];
  logic [XLEN-1:0] op_in    [NI];
  logic            ready    [NI];
  logic [XLEN-1:0] result   [NI];
  logic [11:0]     addr_out [NI];
  logic [VLEN-1:0] pc_out   [NI];
  logic [TW-1:0]   tid_out  [NI];
  logic            hv       [NI];
  logic            err      [NI];
  logic [1:0]      cnt_d2;
  logic [1:0]      cnt_d3;
  logic [0:0]      cnt_d1;

  int     checks;
  int     errors;
  bit     exp_err;
  entry_t sb[$];

  csr_addr_fifo #(.DEPTH(2), .VLEN(VLEN), .XLEN(XLEN), .TRANS_ID_W(TW)) u_d2 (
    .clk_i(clk_i), .rst_ni(rst_n[0]), .flush_i(flush[0]), .valid_i(valid[0]),
    .addr_i(addr_in[0]), .pc_i(pc_in[0]), .trans_id_i(tid_in[0]), .operand_i(op_in[0]),
    .ready_o(ready[0]), .result_o(result[0]), .commit_i(commit[0]), .addr_o(addr_out[0]),
    .pc_o(pc_out[0]), .trans_id_o(tid_out[0]), .head_valid_o(hv[0]), .count_o(cnt_d2),
    .commit_err_o(err[0]));

  csr_addr_fifo #(.DEPTH(3), .VLEN(VLEN), .XLEN(XLEN), .TRANS_ID_W(TW)) u_d3 (
    .clk_i(clk_i), .rst_ni(rst_n[1]), .flush_i(flush[1]), .valid_i(valid[1]),
    .addr_i(addr_in[1]), .pc_i(pc_in[1]), .trans_id_i(tid_in[1]), .operand_i(op_in[1]),
    .ready_o(ready[1]), .result_o(result[1]), .commit_i(commit[1]), .addr_o(addr_out[1]),
    .pc_o(pc_out[1]), .trans_id_o(tid_out[1]), .head_valid_o(hv[1]), .count_o(cnt_d3),
    .commit_err_o(err[1]));

  csr_addr_fifo #(.DEPTH(1), .VLEN(VLEN), .XLEN(XLEN), .TRANS_ID_W(TW)) u_d1 (
    .clk_i(clk_i), .rst_ni(rst_n[2]), .flush_i(flush[2]), .valid_i(valid[2]),
    .addr_i(addr_in[2]), .pc_i(pc_in[2]), .trans_id_i(tid_in[2]), .operand_i(op_in[2]),
    .ready_o(ready[2]), .result_o(result[2]), .commit_i(commit[2]), .addr_o(addr_out[2]),
    .pc_o(pc_out[2]), .trans_id_o(tid_out[2]), .head_valid_o(hv[2]), .count_o(cnt_d1),
    .commit_err_o(err[2]));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic int get_cnt(input int k);
    case (k)
      0:       return int'(cnt_d2);
      1:       return int'(cnt_d3);
      default: return int'(cnt_d1);
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input int k, input string tag);
    check({tag, "_ready"}, ready[k], 1'b1);
    check({tag, "_head_valid"}, hv[k], 1'b0);
    check({tag, "_addr"}, addr_out[k], 12'h000);
    check({tag, "_pc"}, pc_out[k], '0);
    check({tag, "_tid"}, tid_out[k], '0);
    check({tag, "_count"}, get_cnt(k), 0);
    check({tag, "_err"}, err[k], 1'b0);
  endtask

  // Called #1 after a rising edge: drive one cycle of stimulus, check outputs, update scoreboard.
  task automatic cyc(input int k, input bit v, input logic [11:0] a, input bit c, input bit f,
                     input string tag, output bit acc);
    entry_t e;
    bit     exp_rdy;
    e.addr     = a;
    e.pc       = {$urandom(), $urandom()};
    e.tid      = TW'($urandom_range(0, 7));
    valid[k]   = v;
    commit[k]  = c;
    flush[k]   = f;
    addr_in[k] = e.addr;
    pc_in[k]   = e.pc;
    tid_in[k]  = e.tid;
    op_in[k]   = {$urandom(), $urandom()};
    #1;
    exp_rdy = (sb.size() < depth_of(k)) || (c && sb.size() != 0);
    check({tag, "_ready"}, ready[k], exp_rdy);
    check({tag, "_result"}, result[k], op_in[k]);
    check({tag, "_count"}, get_cnt(k), sb.size());
    check({tag, "_head_valid"}, hv[k], sb.size() != 0);
    check({tag, "_addr"}, addr_out[k], (sb.size() != 0) ? sb[0].addr : 12'h000);
    check({tag, "_pc"}, pc_out[k], (sb.size() != 0) ? sb[0].pc : '0);
    check({tag, "_tid"}, tid_out[k], (sb.size() != 0) ? sb[0].tid : '0);
    check({tag, "_err"}, err[k], exp_err);
    exp_err = c && (sb.size() == 0);
    acc     = v && exp_rdy && !f;
    if (f) begin
      sb.delete();
    end else begin
      if (c && sb.size() != 0) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    valid[k]  = 1'b0;
    commit[k] = 1'b0;
    flush[k]  = 1'b0;
  endtask

  initial begin
    bit acc;
    bit v;
    bit c;
    int next;
    int npop;
    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;
    for (int k = 0; k < NI; k++) begin
      rst_n[k]   = 1'b0;
      flush[k]   = 1'b0;
      valid[k]   = 1'b0;
      commit[k]  = 1'b0;
      addr_in[k] = '0;
      pc_in[k]   = '0;
      tid_in[k]  = '0;
      op_in[k]   = '0;
    end
    #3;
    for (int k = 0; k < NI; k++) reset_checks(k, "por");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(posedge clk_i);
    #1;

    // Test 1: fill DEPTH=2 buffer.
    cyc(0, 1, 12'h300, 0, 0, "t1_push0", acc);
    cyc(0, 1, 12'h341, 0, 0, "t1_push1", acc);
    // Test 2: full buffer, commit and issue in the same cycle.
    cyc(0, 1, 12'h305, 1, 0, "t2_full_swap", acc);
    check("t2_swap_accepted", acc, 1'b1);
    cyc(0, 0, 12'h000, 1, 0, "t2_pop341", acc);
    cyc(0, 0, 12'h000, 1, 0, "t2_pop305", acc);
    cyc(0, 0, 12'h000, 0, 0, "t2_empty", acc);
    // Test 3: flush drops a same-cycle push.
    cyc(0, 1, 12'h7c0, 0, 0, "t3_push", acc);
    cyc(0, 1, 12'h7c1, 0, 1, "t3_flush", acc);
    cyc(0, 0, 12'h000, 0, 0, "t3_after", acc);
    // Flush with a full buffer and a same-cycle commit.
    cyc(0, 1, 12'h111, 0, 0, "t3b_push0", acc);
    cyc(0, 1, 12'h222, 0, 0, "t3b_push1", acc);
    cyc(0, 1, 12'h333, 1, 1, "t3b_flush_commit", acc);
    cyc(0, 0, 12'h000, 0, 0, "t3b_after", acc);
    // Test 4: commit on empty pulses commit_err_o for exactly one cycle.
    cyc(0, 0, 12'h000, 1, 0, "t4_bad_commit", acc);
    cyc(0, 0, 12'h000, 0, 0, "t4_err_pulse", acc);
    cyc(0, 0, 12'h000, 0, 0, "t4_err_clear", acc);

    // Test 5: DEPTH=3, random interleaving of 10 ops across pointer wrap.
    exp_err = 1'b0;
    next    = 0;
    npop    = 0;
    for (int n = 0; n < 300 && (next < 10 || sb.size() != 0); n++) begin
      v = (next < 10) && ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 1) == 1);
      if (c && sb.size() != 0) begin
        check("t5_pop_order", addr_out[1], 12'h100 + npop);
        npop++;
      end
      cyc(1, v, 12'(12'h100 + next), c, 0, "t5", acc);
      if (acc) next++;
    end
    check("t5_all_popped", npop, 10);
    cyc(1, 0, 12'h000, 0, 0, "t5_drained", acc);

    // Test 6: DEPTH=1, asynchronous reset mid-stream.
    exp_err = 1'b0;
    cyc(2, 1, 12'h300, 0, 0, "t6_push", acc);
    check("t6_head_before_rst", addr_out[2], 12'h300);
    rst_n[2] = 1'b0;
    #1;
    reset_checks(2, "t6_in_rst");
    sb.delete();
    exp_err = 1'b0;
    #1;
    rst_n[2] = 1'b1;
    @(posedge clk_i);
    #1;
    cyc(2, 1, 12'h301, 0, 0, "t6_push_after", acc);
    cyc(2, 1, 12'h302, 0, 0, "t6_full_blocked", acc);
    check("t6_blocked", acc, 1'b0);
    cyc(2, 0, 12'h000, 1, 0, "t6_pop", acc);
    cyc(2, 0, 12'h000, 0, 0, "t6_empty", acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
